// File: rtl/snake_pkg.sv
// Shared encodings for the snake body engine: directions, colours and FSM states.
package snake_pkg;
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [2:0] BLACK    = 3'b000;
    localparam logic [2:0] HEAD_DEF = 3'b100;

    typedef enum logic [2:0] {
        INIT_DRAW, IDLE, CHECK, ERASE, SHIFT, NECK, HEAD, DEAD
    } state_t;
endpackage

// File: rtl/snake_block_drawer.sv
// Streams one BLK x BLK block as pixels, x-fastest, over a valid/ready handshake.
module snake_block_drawer #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int BLK = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [X_W-1:0] base_x,
    input  logic [Y_W-1:0] base_y,
    input  logic [2:0]     colour,
    input  logic           pix_ready,
    output logic           pix_valid,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic [2:0]     pix_colour,
    output logic           done
);
    localparam int B  = $clog2(BLK);
    localparam int CW = (B == 0) ? 1 : 2 * B;
    localparam logic [CW-1:0] LAST = CW'(BLK * BLK - 1);

    logic [CW-1:0]  cnt;
    logic [X_W-1:0] bx;
    logic [Y_W-1:0] by;
    logic [2:0]     col;
    logic           active;

    // A start on the same cycle as done chains the next block without a gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active <= 1'b0;
            cnt    <= '0;
            bx     <= '0;
            by     <= '0;
            col    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            bx     <= base_x;
            by     <= base_y;
            col    <= colour;
        end else if (active && pix_ready) begin
            if (cnt == LAST) active <= 1'b0;
            else             cnt    <= cnt + CW'(1);
        end
    end

    assign pix_valid  = active;
    assign pix_colour = col;
    assign pix_x      = bx + X_W'(32'(cnt) & (BLK - 1));
    assign pix_y      = by + Y_W'(32'(cnt) >> B);
    assign done       = active && pix_ready && (cnt == LAST);
endmodule

// File: rtl/snake_body_engine.sv
// Snake body store and per-tick move sequencer: steer, collide, grow, erase tail, redraw neck/head.
module snake_body_engine import snake_pkg::*; #(
    parameter int         X_W         = 8,
    parameter int         Y_W         = 7,
    parameter int         MAX_LEN     = 64,
    parameter int         INIT_LEN    = 3,
    parameter int         BLK         = 2,
    parameter int         X_MAX       = 159,
    parameter int         Y_MAX       = 119,
    parameter int         START_X     = 40,
    parameter int         START_Y     = 60,
    parameter int         WRAP        = 1,
    parameter logic [2:0] HEAD_COLOUR = HEAD_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           go,
    input  logic [1:0]                     dir,
    input  logic                           grow,
    input  logic [2:0]                     body_colour,
    input  logic                           pix_ready,
    output logic                           pix_valid,
    output logic [X_W-1:0]                 pix_x,
    output logic [Y_W-1:0]                 pix_y,
    output logic [2:0]                     pix_colour,
    output logic                           busy,
    output logic                           dead,
    output logic [$clog2(MAX_LEN+1)-1:0]   length,
    output logic [X_W-1:0]                 head_x,
    output logic [Y_W-1:0]                 head_y
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN);

    state_t         state, state_nx;
    logic [X_W-1:0] px [MAX_LEN];
    logic [Y_W-1:0] py [MAX_LEN];
    logic [LW-1:0]  len, idx, lim;
    logic [IW-1:0]  idx_i, tail_i, ini_i;
    logic [1:0]     cur_dir, nd;
    logic           grow_pend, grow_now, accept, match, off;
    logic [X_W-1:0] nh_x, nx;
    logic [Y_W-1:0] nh_y, ny;
    logic [X_W:0]   x_inc;
    logic [Y_W:0]   y_inc;
    logic           d_start, d_done;
    logic [X_W-1:0] d_x;
    logic [Y_W-1:0] d_y;
    logic [2:0]     d_col;

    assign idx_i  = idx[IW-1:0];
    assign tail_i = IW'(len - LW'(1));
    assign ini_i  = d_done ? idx_i + IW'(1) : idx_i;
    // The tail vacates this tick unless growing, so it is not a collision target.
    assign lim    = grow_now ? len - LW'(1) : len - LW'(2);
    assign match  = (px[idx_i] == nh_x) && (py[idx_i] == nh_y);
    assign accept = (state == IDLE) && go;
    assign nd     = (dir == (cur_dir ^ 2'd2)) ? cur_dir : dir;
    assign x_inc  = {1'b0, px[0]} + (X_W+1)'(BLK);
    assign y_inc  = {1'b0, py[0]} + (Y_W+1)'(BLK);

    always_comb begin
        nx  = px[0];
        ny  = py[0];
        off = 1'b0;
        case (nd)
            DIR_RIGHT: if (x_inc > (X_W+1)'(X_MAX)) begin off = 1'b1; nx = '0; end
                       else nx = x_inc[X_W-1:0];
            DIR_LEFT:  if (px[0] < X_W'(BLK)) begin off = 1'b1; nx = X_W'(X_MAX - BLK + 1); end
                       else nx = px[0] - X_W'(BLK);
            DIR_DOWN:  if (y_inc > (Y_W+1)'(Y_MAX)) begin off = 1'b1; ny = '0; end
                       else ny = y_inc[Y_W-1:0];
            DIR_UP:    if (py[0] < Y_W'(BLK)) begin off = 1'b1; ny = Y_W'(Y_MAX - BLK + 1); end
                       else ny = py[0] - Y_W'(BLK);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= INIT_DRAW;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        d_start  = 1'b0;
        d_x      = px[0];
        d_y      = py[0];
        d_col    = body_colour;
        case (state)
            INIT_DRAW: begin
                if (d_done && idx == len - LW'(1)) state_nx = IDLE;
                else if (!pix_valid || d_done) begin
                    d_start = 1'b1;
                    d_x     = px[ini_i];
                    d_y     = py[ini_i];
                    d_col   = (ini_i == '0) ? HEAD_COLOUR : body_colour;
                end
            end
            IDLE: if (go) state_nx = (off && WRAP == 0) ? DEAD : CHECK;
            CHECK: begin
                if (lim != '0 && match) state_nx = DEAD;
                else if (lim == '0 || idx == lim) begin
                    if (grow_now) state_nx = SHIFT;
                    else begin
                        state_nx = ERASE;
                        d_start  = 1'b1;
                        d_x      = px[tail_i];
                        d_y      = py[tail_i];
                        d_col    = BLACK;
                    end
                end
            end
            ERASE: if (d_done) state_nx = SHIFT;
            // The neck block is the pre-shift head, latched by the drawer on this edge.
            SHIFT: begin
                state_nx = NECK;
                d_start  = 1'b1;
            end
            NECK: if (d_done) begin
                state_nx = HEAD;
                d_start  = 1'b1;
                d_x      = nh_x;
                d_y      = nh_y;
                d_col    = HEAD_COLOUR;
            end
            HEAD: if (d_done) state_nx = IDLE;
            default: state_nx = DEAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                px[i] <= X_W'(START_X - i * BLK);
                py[i] <= Y_W'(START_Y);
            end
            len       <= LW'(INIT_LEN);
            idx       <= '0;
            cur_dir   <= DIR_RIGHT;
            grow_pend <= 1'b0;
            grow_now  <= 1'b0;
            nh_x      <= '0;
            nh_y      <= '0;
        end else begin
            if (grow && state != DEAD) grow_pend <= 1'b1;
            else if (accept)           grow_pend <= 1'b0;
            if (accept) begin
                grow_now <= grow_pend;
                cur_dir  <= nd;
                nh_x     <= nx;
                nh_y     <= ny;
                idx      <= LW'(1);
            end
            if ((state == INIT_DRAW && d_done) || state == CHECK) idx <= idx + LW'(1);
            if (state == SHIFT) begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    px[i] <= px[i-1];
                    py[i] <= py[i-1];
                end
                px[0] <= nh_x;
                py[0] <= nh_y;
                if (grow_now && len < LW'(MAX_LEN)) len <= len + LW'(1);
            end
        end
    end

    snake_block_drawer #(.X_W(X_W), .Y_W(Y_W), .BLK(BLK)) u_drawer (
        .clk        (clk),
        .rst        (rst),
        .start      (d_start),
        .base_x     (d_x),
        .base_y     (d_y),
        .colour     (d_col),
        .pix_ready  (pix_ready),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .done       (d_done)
    );

    assign busy   = !(state == IDLE || state == DEAD);
    assign dead   = (state == DEAD);
    assign length = len;
    assign head_x = px[0];
    assign head_y = py[0];
endmodule

// File: tb/tb_snake_body_engine.sv
// Scoreboarded bench: a reference snake model queues expected pixels, a monitor pops and compares.
module tb_snake_body_engine;
    logic       clk, rst, go, grow, pix_ready;
    logic [1:0] dir;
    logic [2:0] bc;
    logic       pix_valid, busy, dead;
    logic [7:0] pix_x, head_x;
    logic [6:0] pix_y, head_y;
    logic [2:0] pix_colour;
    logic [6:0] length;

    logic       go0;
    logic [1:0] dir0;
    logic       w_valid, w_busy, w_dead;
    logic [7:0] w_x, w_hx;
    logic [6:0] w_y, w_hy;
    logic [2:0] w_col;
    logic [6:0] w_len;

    int n_chk = 0, n_err = 0;
    int pix_cnt = 0, push_cnt = 0, w_cnt = 0;
    logic [17:0] sb[$];
    logic        hold = 1'b0;
    logic [17:0] held;

    int mx[65], my[65];
    int mlen, mdir;
    bit mdead;

    snake_body_engine u_dut (
        .clk(clk), .rst(rst), .go(go), .dir(dir), .grow(grow), .body_colour(bc),
        .pix_ready(pix_ready), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_colour(pix_colour), .busy(busy), .dead(dead), .length(length),
        .head_x(head_x), .head_y(head_y)
    );

    snake_body_engine #(.START_X(156), .WRAP(0)) u_w0 (
        .clk(clk), .rst(rst), .go(go0), .dir(dir0), .grow(1'b0), .body_colour(bc),
        .pix_ready(1'b1), .pix_valid(w_valid), .pix_x(w_x), .pix_y(w_y),
        .pix_colour(w_col), .busy(w_busy), .dead(w_dead), .length(w_len),
        .head_x(w_hx), .head_y(w_hy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_block(input int x, input int y, input logic [2:0] c);
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
                sb.push_back({8'(x + dx), 7'(y + dy), c});
                push_cnt++;
            end
    endtask

    task automatic model_step(input logic [1:0] d, input bit g);
        int nx, ny, lim;
        bit hit;
        if (int'(d) != (mdir ^ 2)) mdir = int'(d);
        nx = mx[0];
        ny = my[0];
        case (mdir)
            0:       ny -= 2;
            1:       nx += 2;
            2:       ny += 2;
            default: nx -= 2;
        endcase
        if (nx > 159) nx = 0;
        if (nx < 0)   nx = 158;
        if (ny > 119) ny = 0;
        if (ny < 0)   ny = 118;
        lim = g ? mlen - 1 : mlen - 2;
        hit = 1'b0;
        for (int i = 1; i <= lim; i++)
            if (mx[i] == nx && my[i] == ny) hit = 1'b1;
        if (hit) begin
            mdead = 1'b1;
            return;
        end
        if (!g) push_block(mx[mlen-1], my[mlen-1], 3'b000);
        for (int i = mlen; i >= 1; i--) begin
            mx[i] = mx[i-1];
            my[i] = my[i-1];
        end
        mx[0] = nx;
        my[0] = ny;
        if (g && mlen < 64) mlen++;
        push_block(mx[1], my[1], bc);
        push_block(nx, ny, 3'b100);
    endtask

    always @(negedge clk) begin
        logic [17:0] cur, e;
        cur = {pix_x, pix_y, pix_colour};
        if (pix_valid && pix_ready) begin
            if (sb.size() == 0) chk("pix_extra", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("pix", 32'(cur), 32'(e));
            end
            pix_cnt++;
        end
        if (hold && pix_valid) chk("pix_hold", 32'(cur), 32'(held));
        hold = pix_valid && !pix_ready;
        held = cur;
        if (w_valid) w_cnt++;
    end

    task automatic step(input logic [1:0] d, input bit g, input bit bp, input bit tchk);
        int n, p0, q0;
        if (g) begin
            grow = 1'b1;
            @(posedge clk); #1 grow = 1'b0;
        end
        p0 = pix_cnt;
        q0 = push_cnt;
        model_step(d, g);
        dir = d;
        go  = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        n = 0;
        if (bp) begin
            @(posedge clk); @(posedge clk);
            #1 pix_ready = 1'b0;
            go = 1'b1;
            dir = 2'd2;
            @(posedge clk); #1 go = 1'b0;
            repeat (6) @(posedge clk);
            #1 pix_ready = 1'b1;
            n = 9;
        end
        while (busy && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) chk("step_timeout", 32'd1, 32'd0);
        if (tchk) chk("step_latency", 32'(n), 32'd14);
        chk("step_npix", 32'(pix_cnt - p0), 32'(push_cnt - q0));
        chk("step_head_x", 32'(head_x), 32'(mx[0]));
        chk("step_head_y", 32'(head_y), 32'(my[0]));
        chk("step_length", 32'(length), 32'(mlen));
        chk("step_dead", 32'(dead), 32'(mdead));
    endtask

    task automatic w0_go;
        int n;
        dir0 = 2'd1;
        go0  = 1'b1;
        @(posedge clk); #1 go0 = 1'b0;
        n = 0;
        while (w_busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("w0_timeout", 32'd1, 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int n, p0;
        rst = 1'b0; go = 1'b0; grow = 1'b0; dir = 2'd1; pix_ready = 1'b1;
        go0 = 1'b0; dir0 = 2'd1; bc = 3'b011;
        mlen = 3; mdir = 1; mdead = 1'b0;
        for (int i = 0; i < 65; i++) begin
            mx[i] = 40 - 2 * i;
            my[i] = 60;
        end
        for (int i = 0; i < 3; i++) push_block(mx[i], my[i], (i == 0) ? 3'b100 : bc);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_dead", 32'(dead), 32'd0);
        chk("rst_length", 32'(length), 32'd3);
        chk("rst_head", 32'({head_x, head_y}), 32'({8'd40, 7'd60}));
        chk("rst_pix_xy", 32'({pix_x, pix_y, pix_colour}), 32'd0);
        rst = 1'b1;

        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("init_timeout", 32'd1, 32'd0);
        chk("init_npix", 32'(pix_cnt), 32'd12);
        chk("init_sb_empty", 32'(sb.size()), 32'd0);
        chk("init_length", 32'(length), 32'd3);

        step(2'd1, 1'b0, 1'b0, 1'b1);
        chk("first_head_x", 32'(head_x), 32'd42);
        step(2'd3, 1'b0, 1'b0, 1'b0);
        chk("reverse_head_x", 32'(head_x), 32'd44);
        step(2'd1, 1'b1, 1'b0, 1'b0);
        chk("grow_length", 32'(length), 32'd4);
        step(2'd1, 1'b1, 1'b0, 1'b0);
        p0 = pix_cnt;
        step(2'd1, 1'b0, 1'b1, 1'b0);
        chk("bp_npix", 32'(pix_cnt - p0), 32'd12);

        for (int k = 0; k < 80 && mx[0] != 158; k++) step(2'd1, 1'b0, 1'b0, 1'b0);
        chk("pre_wrap_x", 32'(head_x), 32'd158);
        step(2'd1, 1'b0, 1'b0, 1'b0);
        chk("wrap_head_x", 32'(head_x), 32'd0);

        step(2'd0, 1'b0, 1'b0, 1'b0);
        step(2'd3, 1'b0, 1'b0, 1'b0);
        p0 = pix_cnt;
        step(2'd2, 1'b0, 1'b0, 1'b0);
        chk("self_dead", 32'(dead), 32'd1);
        chk("self_length", 32'(length), 32'd5);
        chk("self_npix", 32'(pix_cnt - p0), 32'd0);

        p0 = pix_cnt;
        grow = 1'b1; go = 1'b1; dir = 2'd1;
        @(posedge clk); #1 go = 1'b0; grow = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("dead_go_npix", 32'(pix_cnt - p0), 32'd0);
        chk("dead_go_head", 32'({head_x, head_y}), 32'({8'(mx[0]), 7'(my[0])}));
        chk("dead_go_busy", 32'(busy), 32'd0);
        chk("dead_go_length", 32'(length), 32'd5);

        chk("w0_init_npix", 32'(w_cnt), 32'd12);
        w0_go;
        chk("w0_step_head_x", 32'(w_hx), 32'd158);
        chk("w0_step_npix", 32'(w_cnt), 32'd24);
        w0_go;
        chk("w0_wall_dead", 32'(w_dead), 32'd1);
        chk("w0_wall_npix", 32'(w_cnt), 32'd24);
        chk("w0_wall_head_x", 32'(w_hx), 32'd158);
        w0_go;
        chk("w0_ignored_npix", 32'(w_cnt), 32'd24);
        chk("w0_ignored_busy", 32'(w_busy), 32'd0);
        chk("w0_ignored_dead", 32'(w_dead), 32'd1);

        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
